uart_mem_responder: RTL
=======================

# uart_mem_responder

Memory-side endpoint of the UART memory-access link. It receives 8N1 request frames on `rx`, performs one 32-bit read or write on a local synchronous word memory, and returns the response on `tx`. It sits at the far end of the CPU's memory communication channel, so a simulated or FPGA-resident memory can serve the CPU's load/store traffic.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (≥4).
- `TIMEOUT_CLKS`, default 17360: maximum idle gap between bytes of one frame before the frame is aborted.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  UART serial input, idle high; asynchronous, so it is double-flop synchronised internally.
- `tx`  out  1  UART serial output, idle high.
- `mem_addr`  out  32  word-memory byte address, registered.
- `mem_wdata`  out  32  write data, registered.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_re`  out  1  one-cycle read strobe.
- `mem_rdata`  in  32  read data, valid exactly 1 cycle after `mem_re`.
- `busy`  out  1  high from the first command byte accepted until the last response stop bit ends.
- `frame_error`  out  1  one-cycle pulse on a bad stop bit, bad command, or timeout.

## Operation
- **Frame format.** All multi-byte fields are LSB-first.
  - Write request: `0x57`, then addr[4], then data[4].
  - Read request: `0x52`, then addr[4].
- **Responses.**
  - Write response: a single byte `0x4B`.
  - Read response: data[4].
- **RX.**
  - Start is detected on a falling edge of the synchronised rx.
  - The start bit is re-checked at mid-bit. If it is high there, it was a glitch: ignore it and return to idle.
  - Each data bit is sampled at mid-bit.
  - Stop bit = 0: discard the byte, pulse `frame_error`, and abort the current frame to IDLE.
- **FSM states:** IDLE, ADDR, WDATA, MEM_WR, MEM_RD, RD_WAIT, TX_LOAD, TX_SEND.
  - IDLE:
    - byte `0x57` → ADDR (write flag set).
    - byte `0x52` → ADDR (write flag clear).
    - any other byte → `frame_error` pulse, stay in IDLE.
  - ADDR: collect 4 bytes into the addr register, then go to WDATA if the write flag is set, otherwise MEM_RD.
  - WDATA: collect 4 bytes, then MEM_WR.
  - MEM_WR: `mem_we`=1 for one cycle, load response byte `0x4B`, then TX_LOAD.
  - MEM_RD: `mem_re`=1 for one cycle, then RD_WAIT.
  - RD_WAIT: capture `mem_rdata` into the response shift register, set the byte count to 4, then TX_LOAD.
  - TX_LOAD: hand the next byte to the transmitter, then TX_SEND.
  - TX_SEND: when the byte's stop bit completes:
    - decrement the count;
    - if the count is nonzero, go to TX_LOAD; otherwise go to IDLE.
- **Memory outputs.** `mem_addr`/`mem_wdata` are stable from strobe assertion until the next frame's address bytes start arriving.
- **Timeout.**
  - The inter-byte counter runs in ADDR and WDATA only. It clears on each received byte.
  - Reaching `TIMEOUT_CLKS` → `frame_error` pulse, return to IDLE, and assemble no partial address.
- **RX during response.**
  - Bytes received during MEM_*/TX_* states are dropped without error. Request frames are strictly half-duplex.
  - The RX deserialiser keeps running so its bit alignment is not lost.
- **Reset.** Reset is honoured in any state, including mid-byte TX. It forces all state to IDLE and all counters to 0.

## Timing
- Reset values:
  - `tx`=1, `busy`=0, `frame_error`=0, `mem_we`=0, `mem_re`=0.
  - `mem_addr`=0, `mem_wdata`=0.
- RX byte valid: 2 sync cycles, plus start-edge detect, plus 9.5 bit times, after the start edge.
- Memory strobes:
  - `mem_we` asserts 1 cycle after the last write-data byte is valid.
  - `mem_re` asserts 1 cycle after the last address byte is valid.
- Read path: `mem_rdata` is sampled in the cycle after `mem_re`.
- TX:
  - The first start bit drives `tx`=0 2 cycles after `mem_we`, or 3 cycles after `mem_re`.
  - Each bit lasts exactly `CLKS_PER_BIT` cycles.
  - Bytes are sent back-to-back, so the next start bit follows the previous stop bit with no gap beyond 1 load cycle.
- `busy` drops in the cycle after the last stop bit ends.
- Simultaneous timeout expiry and byte arrival: the byte wins.
- A 32-bit address wraps naturally; no alignment check is made. The memory ignores addr[1:0].

## Test plan
Bench setting: `CLKS_PER_BIT`=4 and `TIMEOUT_CLKS`=200.

- **Write frame.** Send `57 10 00 00 00 EF BE AD DE` → one `mem_we` pulse with `mem_addr`=0x00000010 and `mem_wdata`=0xDEADBEEF; `tx` returns `4B`; `busy` then falls.
- **Read frame.** Send `52 10 00 00 00` with the memory model returning 0xDEADBEEF → one `mem_re` pulse at addr 0x10; `tx` returns `EF BE AD DE` back-to-back; byte spacing is exactly 10 bit times plus 1 cycle.
- **Bad command and glitch.**
  - Send `0x41` → `frame_error` pulses once; no strobe; `tx` stays high.
  - Apply a 1-cycle low glitch on `rx` → nothing happens.
- **Timeout.** Send `57 10 00`, then idle 250 cycles → `frame_error` pulses; a following valid read frame is serviced correctly.
- **Bad stop bit.** During an ADDR byte, hold the stop bit low → `frame_error` pulses; the frame is aborted; no `mem_we`.
- **Reset mid-response.** Assert `reset` for 1 cycle during the 2nd read-response byte → `tx`=1 and `busy`=0 the next cycle; no further bytes; the next frame works.

Source files
------------

// File: rtl/uart_mem_responder.sv
// UART memory-access endpoint: decodes 8N1 read/write request frames from rx,
// performs one 32-bit word access on a synchronous memory and answers on tx.
module uart_mem_responder #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_CLKS = 17360
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        tx,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        frame_error
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RESP_OK = 8'h4B;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, MEM_WR, MEM_RD, RD_WAIT, TX_LOAD, TX_SEND
  } state_t;

  rx_state_t     rx_state;
  logic          rx_s1, rx_s2, rx_prev;
  logic [BW-1:0] rx_clk;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_valid, rx_bad;

  // Receiver runs in every main state so bit alignment survives the response phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_clk   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_bad   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads pre-edge values.
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_valid <= 1'b0;
      rx_bad   <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            rx_clk   <= '0;
          end
        end
        RX_START: begin
          if (rx_clk == HALF_LAST) begin
            rx_clk   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_clk <= rx_clk + BW'(1);
          end
        end
        RX_DATA: begin
          if (rx_clk == BIT_LAST) begin
            rx_clk   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_clk <= rx_clk + BW'(1);
          end
        end
        default: begin
          if (rx_clk == BIT_LAST) begin
            rx_clk   <= '0;
            rx_state <= RX_IDLE;
            rx_valid <= rx_s2;
            rx_bad   <= !rx_s2;
          end else begin
            rx_clk <= rx_clk + BW'(1);
          end
        end
      endcase
    end
  end

  state_t        state;
  logic          is_write;
  logic [1:0]    byte_cnt;
  logic [31:0]   addr_sh, data_sh, resp_sh;
  logic [2:0]    resp_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [BW-1:0] tx_clk;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_frame;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      is_write    <= 1'b0;
      byte_cnt    <= '0;
      addr_sh     <= '0;
      data_sh     <= '0;
      resp_sh     <= '0;
      resp_cnt    <= '0;
      tmo_cnt     <= '0;
      tx_clk      <= '0;
      tx_bit      <= '0;
      tx_frame    <= '0;
      tx          <= 1'b1;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      busy        <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (rx_shift == CMD_WR || rx_shift == CMD_RD) begin
              is_write <= (rx_shift == CMD_WR);
              byte_cnt <= '0;
              tmo_cnt  <= '0;
              busy     <= 1'b1;
              state    <= ADDR;
            end else begin
              frame_error <= 1'b1;
            end
          end else if (rx_bad) begin
            frame_error <= 1'b1;
          end
        end
        ADDR, WDATA: begin
          if (rx_bad || (!rx_valid && tmo_cnt == TMO_LAST)) begin
            // Partial fields stay in the shifters; mem_addr/mem_wdata keep the last access.
            frame_error <= 1'b1;
            busy        <= 1'b0;
            tmo_cnt     <= '0;
            state       <= IDLE;
          end else if (rx_valid) begin
            tmo_cnt  <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (state == ADDR) begin
              addr_sh <= {rx_shift, addr_sh[31:8]};
              if (byte_cnt == 2'd3) begin
                if (is_write) begin
                  state <= WDATA;
                end else begin
                  mem_addr <= {rx_shift, addr_sh[31:8]};
                  mem_re   <= 1'b1;
                  state    <= MEM_RD;
                end
              end
            end else begin
              data_sh <= {rx_shift, data_sh[31:8]};
              if (byte_cnt == 2'd3) begin
                mem_addr  <= addr_sh;
                mem_wdata <= {rx_shift, data_sh[31:8]};
                mem_we    <= 1'b1;
                state     <= MEM_WR;
              end
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        MEM_WR: begin
          resp_sh  <= {24'h0, RESP_OK};
          resp_cnt <= 3'd1;
          state    <= TX_LOAD;
        end
        MEM_RD: begin
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          resp_sh  <= mem_rdata;
          resp_cnt <= 3'd4;
          state    <= TX_LOAD;
        end
        TX_LOAD: begin
          tx       <= 1'b0;
          tx_frame <= {1'b1, resp_sh[7:0]};
          resp_sh  <= resp_sh >> 8;
          tx_bit   <= '0;
          tx_clk   <= '0;
          state    <= TX_SEND;
        end
        default: begin
          if (tx_clk == BIT_LAST) begin
            tx_clk <= '0;
            if (tx_bit == 4'd9) begin
              resp_cnt <= resp_cnt - 3'd1;
              if (resp_cnt == 3'd1) begin
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                state <= TX_LOAD;
              end
            end else begin
              tx       <= tx_frame[0];
              tx_frame <= {1'b0, tx_frame[8:1]};
              tx_bit   <= tx_bit + 4'd1;
            end
          end else begin
            tx_clk <= tx_clk + BW'(1);
          end
        end
      endcase
    end
  end

endmodule
